// File: rtl/systolic_ctrl_2x2.sv
// Controller for a 2x2 output-stationary systolic array: loads A/B operands,
// drives the skewed feeds, waits for the array to drain, then streams C out.
module systolic_ctrl_2x2 #(
   parameter int WIDTH = 8,
   parameter int DRAIN = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             cfg_relu,
   output logic             arr_clear,
   output logic             arr_activation,
   output logic [WIDTH-1:0] arr_a0,
   output logic [WIDTH-1:0] arr_a1,
   output logic [WIDTH-1:0] arr_b0,
   output logic [WIDTH-1:0] arr_b1,
   input  logic [WIDTH-1:0] c00,
   input  logic [WIDTH-1:0] c01,
   input  logic [WIDTH-1:0] c10,
   input  logic [WIDTH-1:0] c11,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy
);

   localparam int DCW = 16;

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_CLEAR   = 3'd1,
      S_FEED    = 3'd2,
      S_DRAIN   = 3'd3,
      S_CAPTURE = 3'd4,
      S_OUT     = 3'd5
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [2:0]       r_lidx;
   logic [1:0]       r_fcnt;
   logic [DCW-1:0]   r_dcnt;
   logic [1:0]       r_oidx;
   // Load order: A00,A01,A10,A11,B00,B01,B10,B11
   logic [WIDTH-1:0] r_mat [8];
   logic [WIDTH-1:0] r_res [4];

   logic w_load_acc;
   logic w_out_acc;
   logic w_feed_last;
   logic w_drain_last;

   assign w_load_acc   = (r_state == S_LOAD) && in_valid;
   assign w_out_acc    = (r_state == S_OUT) && out_ready;
   assign w_feed_last  = (r_fcnt == 2'd2);
   assign w_drain_last = (r_dcnt == DCW'(DRAIN - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD:    if (w_load_acc && (r_lidx == 3'd7)) w_next = S_CLEAR;
         S_CLEAR:   w_next = S_FEED;
         S_FEED:    if (w_feed_last) w_next = (DRAIN == 0) ? S_CAPTURE : S_DRAIN;
         S_DRAIN:   if (w_drain_last) w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_OUT;
         S_OUT:     if (w_out_acc && (r_oidx == 2'd3)) w_next = S_LOAD;
         default:   w_next = S_LOAD;
      endcase
   end

   // Outputs decode straight from state so an async reset takes effect at once
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b1;
      arr_clear = 1'b0;
      arr_a0    = '0;
      arr_a1    = '0;
      arr_b0    = '0;
      arr_b1    = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      case (r_state)
         S_LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         S_CLEAR: arr_clear = 1'b1;
         S_FEED: begin
            case (r_fcnt)
               2'd0: begin
                  arr_a0 = r_mat[0];
                  arr_b0 = r_mat[4];
               end
               2'd1: begin
                  arr_a0 = r_mat[1];
                  arr_a1 = r_mat[2];
                  arr_b0 = r_mat[6];
                  arr_b1 = r_mat[5];
               end
               2'd2: begin
                  arr_a1 = r_mat[3];
                  arr_b1 = r_mat[7];
               end
               default: ;
            endcase
         end
         S_OUT: begin
            out_valid = 1'b1;
            out_data  = r_res[r_oidx];
            out_last  = (r_oidx == 2'd3);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_LOAD;
         r_lidx         <= '0;
         r_fcnt         <= '0;
         r_dcnt         <= '0;
         r_oidx         <= '0;
         arr_activation <= 1'b0;
         for (int i = 0; i < 4; i++) r_res[i] <= '0;
      end else begin
         r_state <= w_next;
         // 3-bit index wraps back to 0 after the eighth word
         if (w_load_acc) r_lidx <= r_lidx + 3'd1;
         if (w_load_acc && (r_lidx == 3'd7)) arr_activation <= cfg_relu;
         if (r_state == S_FEED) r_fcnt <= w_feed_last ? 2'd0 : r_fcnt + 2'd1;
         if (r_state == S_DRAIN) r_dcnt <= w_drain_last ? '0 : r_dcnt + DCW'(1);
         if (r_state == S_CAPTURE) begin
            r_res[0] <= c00;
            r_res[1] <= c01;
            r_res[2] <= c10;
            r_res[3] <= c11;
         end
         if (w_out_acc) r_oidx <= r_oidx + 2'd1;
      end
   end

   // Operand storage carries no reset; it persists until the next job overwrites it
   always_ff @(posedge clk) begin
      if (w_load_acc) r_mat[r_lidx] <= in_data;
   end

endmodule

// File: tb/tb_systolic_ctrl_2x2.sv
// Bench for systolic_ctrl_2x2: directed and random jobs against a matrix-product
// reference, with a small accumulate array model closing the feed/result loop.
`timescale 1ns/1ps
module tb_systolic_ctrl_2x2;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         cfg_relu = 1'b0;
   logic         arr_clear, arr_activation;
   logic [W-1:0] arr_a0, arr_a1, arr_b0, arr_b1;
   logic [W-1:0] c00, c01, c10, c11;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_last, busy;

   int tests = 0;
   int fails = 0;
   int clr_cnt = 0;

   always #5 clk = ~clk;

   systolic_ctrl_2x2 #(.WIDTH(W), .DRAIN(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cfg_relu(cfg_relu), .arr_clear(arr_clear), .arr_activation(arr_activation),
      .arr_a0(arr_a0), .arr_a1(arr_a1), .arr_b0(arr_b0), .arr_b1(arr_b1),
      .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   // Output-stationary 2x2 array: a moves right, b moves down, one register per hop
   logic [W-1:0] acc [4];
   logic [W-1:0] ah0, ah1, bv0, bv1;
   always @(posedge clk) begin
      if (arr_clear) begin
         for (int i = 0; i < 4; i++) acc[i] <= '0;
         ah0 <= '0; ah1 <= '0; bv0 <= '0; bv1 <= '0;
      end else begin
         acc[0] <= acc[0] + W'(arr_a0 * arr_b0);
         acc[1] <= acc[1] + W'(ah0 * arr_b1);
         acc[2] <= acc[2] + W'(arr_a1 * bv0);
         acc[3] <= acc[3] + W'(ah1 * bv1);
         ah0 <= arr_a0; ah1 <= arr_a1; bv0 <= arr_b0; bv1 <= arr_b1;
      end
   end

   function automatic logic [W-1:0] act(input logic [W-1:0] v, input logic en);
      return (en && v[W-1]) ? '0 : v;
   endfunction

   assign c00 = act(acc[0], arr_activation);
   assign c01 = act(acc[1], arr_activation);
   assign c10 = act(acc[2], arr_activation);
   assign c11 = act(acc[3], arr_activation);

   always @(negedge clk) if (arr_clear === 1'b1) clr_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset(input string nm);
      check({nm, "/in_ready"}, in_ready, 1);
      check({nm, "/busy"}, busy, 0);
      check({nm, "/clear"}, arr_clear, 0);
      check({nm, "/act"}, arr_activation, 0);
      check({nm, "/feeds"}, {arr_a0, arr_a1, arr_b0, arr_b1}, 0);
      check({nm, "/out_valid"}, out_valid, 0);
      check({nm, "/out_last"}, out_last, 0);
      check({nm, "/out_data"}, out_data, 0);
   endtask

   function automatic int el(input logic [63:0] m, input int k);
      logic [W-1:0] v;
      v = m[k*8 +: 8];
      return int'($signed(v));
   endfunction

   // C[i][j] = sum_k A[i][k]*B[k][j], wrapped to W bits, optional ReLU
   function automatic logic [31:0] ref_c(input logic [63:0] m, input logic relu);
      logic [31:0] r;
      logic [W-1:0] v;
      int s;
      r = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            s = el(m, 2*i) * el(m, 4+j) + el(m, 2*i+1) * el(m, 6+j);
            v = s[W-1:0];
            if (relu && v[W-1]) v = '0;
            r[(2*i+j)*8 +: 8] = v;
         end
      end
      return r;
   endfunction

   task automatic run_job(input string nm, input logic [63:0] m, input logic relu,
                          input logic [31:0] exp, input logic [15:0] pat, input int plen,
                          input logic hold, input int abort_k);
      int c0, idx, cyc;
      logic hs;
      logic [31:0] fe;
      c0 = clr_cnt;
      for (int w = 0; w < 8; w++) begin
         if (!hold) begin
            while ($urandom_range(3) == 0) begin
               in_valid = 1'b0;
               in_data  = W'($urandom);
               step();
            end
         end
         in_valid = 1'b1;
         in_data  = m[w*8 +: 8];
         cfg_relu = (w == 7) ? relu : ~relu;
         check({nm, "/load_ready"}, in_ready, 1);
         check({nm, "/load_busy"}, busy, 0);
         step();
      end
      in_valid = hold;
      in_data  = W'($urandom);
      cfg_relu = 1'($urandom);
      for (int k = 1; k <= 7; k++) begin
         if (k == abort_k) begin
            rst = 1'b1;
            #1;
            check_reset({nm, "/abort"});
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b0;
            return;
         end
         fe = (k == 2) ? {m[0+:8], 8'h00, m[32+:8], 8'h00} :
              (k == 3) ? {m[8+:8], m[16+:8], m[48+:8], m[40+:8]} :
              (k == 4) ? {8'h00, m[24+:8], 8'h00, m[56+:8]} : 32'h0;
         check({nm, "/feeds"}, {arr_a0, arr_a1, arr_b0, arr_b1}, fe);
         check({nm, "/clear"}, arr_clear, (k == 1));
         check({nm, "/busy"}, busy, 1);
         check({nm, "/in_ready"}, in_ready, 0);
         check({nm, "/early_valid"}, out_valid, 0);
         if (k == 1) check({nm, "/act_latch"}, arr_activation, relu);
         step();
         in_data  = W'($urandom);
         cfg_relu = 1'($urandom);
      end
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 60) begin
         out_ready = (plen > 0) ? pat[cyc % plen] : 1'($urandom);
         check({nm, "/out_valid"}, out_valid, 1);
         check({nm, "/out_data"}, out_data, exp[idx*8 +: 8]);
         check({nm, "/out_last"}, out_last, (idx == 3));
         check({nm, "/out_in_ready"}, in_ready, 0);
         check({nm, "/out_feeds"}, {arr_a0, arr_a1, arr_b0, arr_b1, 7'd0, arr_clear}, 0);
         hs = out_ready;
         step();
         in_data = W'($urandom);
         if (hs) idx++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({nm, "/out_count"}, idx, 4);
      check({nm, "/done_valid"}, out_valid, 0);
      check({nm, "/done_busy"}, busy, 0);
      check({nm, "/done_ready"}, in_ready, 1);
      check({nm, "/done_data"}, {out_data, 7'd0, out_last}, 0);
      check({nm, "/act_hold"}, arr_activation, relu);
      check({nm, "/clear_pulses"}, clr_cnt - c0, 1);
   endtask

   initial begin
      logic [63:0] m37, m38, mr;
      logic relu;
      m37 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      m38 = {8'hFB, 8'h04, 8'h02, 8'hFD, 8'h01, 8'h00, 8'h00, 8'h01};

      rst = 1'b1;
      #1;
      check_reset("reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run_job("basic", m37, 1'b0, {8'd50, 8'd43, 8'd22, 8'd19}, 16'h0001, 1, 1'b0, 0);
      run_job("relu1", m38, 1'b1, {8'h00, 8'h04, 8'h02, 8'h00}, 16'h0001, 1, 1'b0, 0);
      run_job("relu0", m38, 1'b0, {8'hFB, 8'h04, 8'h02, 8'hFD}, 16'h0001, 1, 1'b0, 0);
      run_job("stall", m37, 1'b0, {8'd50, 8'd43, 8'd22, 8'd19}, 16'h0069, 7, 1'b0, 0);
      run_job("abort", m38, 1'b1, 32'h0, 16'h0001, 1, 1'b0, 3);
      run_job("after_rst", m37, 1'b0, {8'd50, 8'd43, 8'd22, 8'd19}, 16'h0001, 1, 1'b0, 0);
      run_job("hold1", m37, 1'b1, ref_c(m37, 1'b1), 16'h0001, 1, 1'b1, 0);
      run_job("hold2", m38, 1'b1, ref_c(m38, 1'b1), 16'h0005, 3, 1'b1, 0);

      for (int j = 0; j < 10; j++) begin
         mr   = {$urandom, $urandom};
         relu = 1'($urandom);
         run_job($sformatf("rand%0d", j), mr, relu, ref_c(mr, relu), 16'h0, 0, 1'($urandom), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
